apb_reg_bridge: RTL and testbench
=================================

APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

Interface
REQ-001 The block SHALL have parameters, one per line:
  width  8  data width of APB and register-bank data paths
  addressWidth  8  address width of APB and register-bank address
  NUM_REGS  16  number of implemented register addresses; valid range is 0..NUM_REGS-1
REQ-002 The block SHALL have ports, one per line:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  reset, asynchronous, active-high
  psel  in  1  APB select
  penable  in  1  APB enable (access phase)
  pwrite  in  1  APB direction, 1 = write
  paddr  in  addressWidth  APB address
  pwdata  in  width  APB write data
  prdata  out  width  APB read data
  pready  out  1  APB transfer complete
  pslverr  out  1  APB error response
  address  out  addressWidth  register-bank address
  writeEnable  out  1  register-bank write strobe
  writeData  out  width  register-bank write data
  readEnable  out  1  register-bank read strobe
  readData  in  width  register-bank read data, valid one cycle after readEnable
  err_count  out  8  count of error responses, saturating

Function
REQ-003 The block SHALL use states IDLE, ISSUE, CAPTURE, RESP. All outputs SHALL be registered.
REQ-004 In IDLE, psel=1 and penable=0 (setup phase) SHALL latch paddr, pwdata and pwrite into address, writeData and an internal direction bit.
REQ-005 Valid setup (paddr < NUM_REGS): at that edge, set writeEnable (pwrite=1) or readEnable (pwrite=0) and go to ISSUE.
REQ-006 Invalid setup (paddr >= NUM_REGS): issue no strobe, set pready=1 and pslverr=1, set prdata=0, go to RESP. pready SHALL therefore be high in the first access cycle.
REQ-007 writeEnable and readEnable SHALL each be high for exactly one cycle per transfer and SHALL never be high together.
REQ-008 ISSUE, write: clear the strobe, set pready=1 and pslverr=0, go to RESP. pready SHALL be high 2 cycles after the setup cycle.
REQ-009 ISSUE, read: clear the strobe and go to CAPTURE.
REQ-010 CAPTURE: set prdata <= readData, pready=1, pslverr=0, go to RESP. pready SHALL be high 3 cycles after the setup cycle.
REQ-011 RESP: pready and pslverr SHALL be high for exactly one cycle. At the next edge, clear both and return to IDLE. prdata SHALL hold its value until the next read completes.
REQ-012 address and writeData SHALL hold their values from setup until the next setup.
REQ-013 The block SHALL accept a new setup phase in the cycle after the RESP cycle, so back-to-back transfers need no idle gap.
REQ-014 If psel=0 in ISSUE or CAPTURE (master abort), the block SHALL return to IDLE at the next edge with pready=0. An already-issued strobe is not retracted (it is only one cycle wide).
REQ-015 In IDLE, penable=1 without a preceding setup SHALL be ignored, with no strobe and no pready.
REQ-016 err_count SHALL increment by 1 on each error response and saturate at 255 without wrapping.

Reset
REQ-017 rst=1 SHALL immediately and asynchronously force state=IDLE and drive to 0: prdata, pready, pslverr, address, writeEnable, writeData, readEnable and err_count.
REQ-018 Reset asserted mid-transfer SHALL abort the transfer with no pending strobe or pready after release. The first setup after release SHALL be handled normally.

Verification
REQ-019 Write paddr=3, pwdata=0xA5 -> in the cycle after setup: writeEnable=1, address=3, writeData=0xA5; one cycle later pready=1, pslverr=0; no readEnable at any point.
REQ-020 Read paddr=5 with readData driven to 0x3C one cycle after readEnable -> pready=1 in setup+3 with prdata=0x3C and pslverr=0.
REQ-021 Read paddr=16 (NUM_REGS=16) -> no strobe; pready=1 and pslverr=1 in the first access cycle; prdata=0; err_count increments from 0 to 1.
REQ-022 Back-to-back write(2,0x11) then read(2) with no idle cycle -> both complete with correct strobes; strobes never overlap.
REQ-023 Read with psel dropped during CAPTURE -> return to IDLE, pready never asserted; the next transfer completes normally.
REQ-024 Assert rst in the ISSUE state of a write -> all outputs 0 immediately; after release, no pready appears until a new setup; 300 error transfers -> err_count=255.

Source files
------------

// File: rtl/apb_reg_bridge_if.sv
// APB slave bus plus register-bank side channel for apb_reg_bridge.
// The master modport is the environment view (APB master and register bank);
// the slave modport is the bridge view.
interface apb_reg_bridge_if #(
    parameter int unsigned width        = 8,
    parameter int unsigned addressWidth = 8
);

    // APB side
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [addressWidth-1:0] paddr;
    logic [width-1:0]        pwdata;
    logic [width-1:0]        prdata;
    logic                    pready;
    logic                    pslverr;

    // Register-bank side
    logic [addressWidth-1:0] address;
    logic                    writeEnable;
    logic [width-1:0]        writeData;
    logic                    readEnable;
    logic [width-1:0]        readData;

    // Status
    logic [7:0]              err_count;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        output readData,
        input  prdata,
        input  pready,
        input  pslverr,
        input  address,
        input  writeEnable,
        input  writeData,
        input  readEnable,
        input  err_count
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        input  readData,
        output prdata,
        output pready,
        output pslverr,
        output address,
        output writeEnable,
        output writeData,
        output readEnable,
        output err_count
    );

endinterface

// File: rtl/apb_reg_bridge.sv
// APB slave that forwards each transfer to a simple register bank as a
// one-cycle write or read strobe. Reads take one extra cycle because the bank
// returns readData the cycle after readEnable. Addresses at or above NUM_REGS
// are answered with an error response and counted in err_count.
// Every output is a flop; the FSM computes all next values in one process.
module apb_reg_bridge #(
    parameter int unsigned width        = 8,
    parameter int unsigned addressWidth = 8,
    parameter int unsigned NUM_REGS     = 16
) (
    input logic             clk,
    input logic             rst,
    apb_reg_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [width-1:0]        prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [addressWidth-1:0] address_q, address_d;
    logic                    write_en_q, write_en_d;
    logic [width-1:0]        write_data_q, write_data_d;
    logic                    read_en_q, read_en_d;
    logic [7:0]              err_count_q, err_count_d;
    // Direction of the transfer in flight, 1 = write
    logic                    dir_q, dir_d;

    logic setup;
    logic addr_valid;

    // Setup phase: selected but not yet in the access phase
    assign setup      = bus.psel & ~bus.penable;
    assign addr_valid = (32'(bus.paddr) < NUM_REGS);

    // Next-state and next-output logic; strobes and response flags default low
    always_comb begin
        state_d      = state_q;
        prdata_d     = prdata_q;
        pready_d     = 1'b0;
        pslverr_d    = 1'b0;
        address_d    = address_q;
        write_en_d   = 1'b0;
        write_data_d = write_data_q;
        read_en_d    = 1'b0;
        err_count_d  = err_count_q;
        dir_d        = dir_q;

        unique case (state_q)
            StIdle: begin
                // A lone penable without a setup phase falls through here
                if (setup) begin
                    address_d    = bus.paddr;
                    write_data_d = bus.pwdata;
                    dir_d        = bus.pwrite;
                    if (addr_valid) begin
                        write_en_d = bus.pwrite;
                        read_en_d  = ~bus.pwrite;
                        state_d    = StIssue;
                    end else begin
                        // Error answered in the first access cycle, no strobe
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        state_d = StResp;
                    end
                end
            end

            StIssue: begin
                if (!bus.psel) begin
                    // Master abort; the strobe has already been issued and ends here
                    state_d = StIdle;
                end else if (dir_q) begin
                    pready_d = 1'b1;
                    state_d  = StResp;
                end else begin
                    state_d = StCapture;
                end
            end

            StCapture: begin
                if (!bus.psel) begin
                    state_d = StIdle;
                end else begin
                    prdata_d = bus.readData;
                    pready_d = 1'b1;
                    state_d  = StResp;
                end
            end

            StResp: begin
                // pready/pslverr drop through their defaults
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            address_q    <= '0;
            write_en_q   <= 1'b0;
            write_data_q <= '0;
            read_en_q    <= 1'b0;
            err_count_q  <= 8'd0;
            dir_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prdata_q     <= prdata_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            address_q    <= address_d;
            write_en_q   <= write_en_d;
            write_data_q <= write_data_d;
            read_en_q    <= read_en_d;
            err_count_q  <= err_count_d;
            dir_q        <= dir_d;
        end
    end

    assign bus.prdata      = prdata_q;
    assign bus.pready      = pready_q;
    assign bus.pslverr     = pslverr_q;
    assign bus.address     = address_q;
    assign bus.writeEnable = write_en_q;
    assign bus.writeData   = write_data_q;
    assign bus.readEnable  = read_en_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge: directed steps plus randomized
// transfers, compared against a transaction-level model of the register bank.
module tb_apb_reg_bridge;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    apb_reg_bridge_if #(.width(W), .addressWidth(AW)) bus ();

    apb_reg_bridge #(
        .width        (W),
        .addressWidth (AW),
        .NUM_REGS     (NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Register bank: writes on writeEnable, readData valid the cycle after readEnable
    logic [W-1:0] bank [256];

    function automatic logic [7:0] seed_val(input int i);
        return 8'(i * 29 + 7);
    endfunction

    // Bank behaviour, reloaded with seed values while reset is held
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) bank[i] <= seed_val(i);
            bus.readData <= '0;
        end else begin
            if (bus.writeEnable) bank[bus.address] <= bus.writeData;
            if (bus.readEnable) bus.readData <= bank[bus.address];
        end
    end

    // Running strobe counts, sampled mid-cycle
    int we_total = 0;
    int re_total = 0;
    int overlap_total = 0;

    always @(negedge clk) begin
        if (bus.writeEnable === 1'b1) we_total++;
        if (bus.readEnable === 1'b1) re_total++;
        if (bus.writeEnable === 1'b1 && bus.readEnable === 1'b1) overlap_total++;
    end

    // Reference model: expected register contents, last read data, error count
    logic [7:0] exp_mem [256];
    logic [7:0] exp_prdata;
    int         exp_err;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) exp_mem[i] = seed_val(i);
        exp_prdata = 8'h00;
        exp_err    = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prdata"}, 32'(bus.prdata), 0);
        check({tag, "_pready"}, 32'(bus.pready), 0);
        check({tag, "_pslverr"}, 32'(bus.pslverr), 0);
        check({tag, "_address"}, 32'(bus.address), 0);
        check({tag, "_we"}, 32'(bus.writeEnable), 0);
        check({tag, "_wdata"}, 32'(bus.writeData), 0);
        check({tag, "_re"}, 32'(bus.readEnable), 0);
        check({tag, "_errcnt"}, 32'(bus.err_count), 0);
    endtask

    task automatic idle(input int n);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One APB transfer; drop_in_capture releases psel in the CAPTURE cycle of a read
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input bit drop_in_capture);
        bit valid = int'(addr) < NR;
        int we0;
        int re0;
        int lat;
        int exp_lat;

        @(negedge clk);
        check("idle_pready", 32'(bus.pready), 0);
        check("idle_pslverr", 32'(bus.pslverr), 0);
        we0 = we_total;
        re0 = re_total;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = data;

        @(negedge clk);
        bus.penable = 1'b1;
        check("access_we", 32'(bus.writeEnable), 32'(valid && wr));
        check("access_re", 32'(bus.readEnable), 32'(valid && !wr));
        check("access_address", 32'(bus.address), 32'(addr));
        check("access_wdata", 32'(bus.writeData), 32'(data));

        if (drop_in_capture) begin
            @(negedge clk);
            check("abort_pready", 32'(bus.pready), 0);
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("abort_pready", 32'(bus.pready), 0);
            end
            check("abort_re_count", 32'(re_total - re0), 1);
            check("abort_we_count", 32'(we_total - we0), 0);
            check("abort_prdata", 32'(bus.prdata), 32'(exp_prdata));
            return;
        end

        lat = 1;
        while (bus.pready !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end

        exp_lat = !valid ? 1 : (wr ? 2 : 3);
        if (!valid) begin
            exp_err    = (exp_err < 255) ? exp_err + 1 : 255;
            exp_prdata = 8'h00;
        end else if (wr) begin
            exp_mem[addr] = data;
        end else begin
            exp_prdata = exp_mem[addr];
        end

        check("latency", 32'(lat), 32'(exp_lat));
        check("pslverr", 32'(bus.pslverr), 32'(!valid));
        check("prdata", 32'(bus.prdata), 32'(exp_prdata));
        check("err_count", 32'(bus.err_count), 32'(exp_err));
        check("we_count", 32'(we_total - we0), 32'(valid && wr));
        check("re_count", 32'(re_total - re0), 32'(valid && !wr));
        check("overlap", 32'(overlap_total), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;

        rst         = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic write, write/read of a known value, out-of-range read
        xfer(1'b1, 8'd3, 8'hA5, 1'b0);
        idle(1);
        xfer(1'b1, 8'd5, 8'h3C, 1'b0);
        idle(1);
        xfer(1'b0, 8'd5, 8'h00, 1'b0);
        idle(2);
        xfer(1'b0, 8'd16, 8'h00, 1'b0);

        // Back-to-back write then read, no idle gap
        xfer(1'b1, 8'd2, 8'h11, 1'b0);
        xfer(1'b0, 8'd2, 8'h00, 1'b0);

        // Read aborted during CAPTURE, then a normal read
        xfer(1'b0, 8'd4, 8'h00, 1'b1);
        xfer(1'b0, 8'd4, 8'h00, 1'b0);

        // Stray penable in IDLE without setup
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_we", 32'(bus.writeEnable), 0);
            check("stray_re", 32'(bus.readEnable), 0);
            check("stray_pready", 32'(bus.pready), 0);
        end
        idle(1);

        // Randomized mix, including out-of-range addresses and occasional gaps
        for (int k = 0; k < 60; k++) begin
            wr   = 1'($urandom);
            addr = 8'($urandom_range(19, 0));
            data = 8'($urandom);
            xfer(wr, addr, data, (!wr && addr < 8'd16 && $urandom_range(7, 0) == 0));
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(2, 1)));
        end

        // Reset during the ISSUE cycle of a write
        idle(1);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 8'd7;
        bus.pwdata  = 8'h99;
        @(negedge clk);
        bus.penable = 1'b1;
        check("pre_reset_we", 32'(bus.writeEnable), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            check("post_reset_pready", 32'(bus.pready), 0);
            check("post_reset_we", 32'(bus.writeEnable), 0);
        end
        xfer(1'b1, 8'd7, 8'h5E, 1'b0);
        xfer(1'b0, 8'd7, 8'h00, 1'b0);

        // Saturation of the error counter
        for (int k = 0; k < 300; k++) begin
            xfer(1'($urandom), 8'($urandom_range(255, 16)), 8'($urandom), 1'b0);
        end
        check("err_count_saturated", 32'(bus.err_count), 255);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
